regfile_read_arbiter: RTL and testbench
=======================================

REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 Parameter ZERO_R0, default 1, meaning: 1 = reads of register 0 return 32'h0 regardless of mux data.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 read request.
REQ-005 req0_addr  input  5  requester 0 register index.
REQ-006 req0_ready  output  1  requester 0 request accepted this cycle.
REQ-007 rsp0_valid  output  1  requester 0 read data valid, one-cycle pulse.
REQ-008 rsp0_data  output  32  requester 0 read data.
REQ-009 req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data SHALL mirror REQ-004..REQ-008 for requester 1.
REQ-010 wr_en  input  1  register-file write strobe, same cycle as the write commits.
REQ-011 wr_addr  input  5  register-file write index.
REQ-012 wr_data  input  32  register-file write data.
REQ-013 mux_sel  output  5  select to the shared 32:1 registered read mux.
REQ-014 mux_enable  output  1  capture enable to the shared read mux.
REQ-015 mux_out  input  32  registered mux output, valid one cycle after mux_enable.

Function
REQ-016 The block SHALL grant at most one request per cycle; grant means reqN_ready=1 in the same cycle as reqN_valid=1.
REQ-017 The block SHALL arbitrate round-robin: if both requests are valid, it SHALL grant the requester not granted most recently; a lone valid request SHALL be granted immediately.
REQ-018 On a grant, the block SHALL drive mux_sel=granted addr and mux_enable=1 in the same cycle; with no grant, mux_enable=0 and mux_sel SHALL hold its last value.
REQ-019 Latency SHALL be exactly 1 cycle: grant at cycle N yields rspN_valid=1 at cycle N+1 for the granted requester only.
REQ-020 Response data SHALL be mux_out, except: (a) if wr_en=1 and wr_addr equals the granted addr at grant cycle N, data SHALL be wr_data captured at N (write bypass); (b) if ZERO_R0=1 and addr=0, data SHALL be 32'h0, which takes priority over (a).
REQ-021 Grants SHALL be accepted back-to-back with throughput one per cycle; no response backpressure exists, and rspN_valid SHALL never stay high for 2 cycles from one grant.
REQ-022 The round-robin pointer SHALL update only on a grant; idle cycles SHALL NOT change it.
REQ-023 rspN_data SHALL hold its last value while rspN_valid=0.
REQ-024 Internal state: last_grant (1 bit), pipeline register {valid, id, addr_is_zero, bypass_hit, bypass_data}.

Reset
REQ-025 While rst=1 at a posedge: req0_ready=req1_ready=0, mux_enable=0, rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0, mux_sel=0, last_grant=1 (requester 0 wins the first contention).
REQ-026 A grant issued in the cycle rst asserts SHALL be discarded; no response pulse SHALL follow reset.
REQ-027 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-028 A shared package SHALL hold REG_ADDR_W=5, REG_DATA_W=32, NUM_READ_REQ=2 and the response pipeline record typedef.
REQ-029 One sub-module, rr_arbiter2 (two-way round-robin grant with pointer), SHALL be factored out; the 32:1 mux SHALL remain external.

Verification
REQ-030 Reset, then req0_valid=1 with addr=5 and mux_out=32'hDEADBEEF the next cycle -> req0_ready=1, mux_sel=5, mux_enable=1 at N; rsp0_valid=1, rsp0_data=32'hDEADBEEF at N+1.
REQ-031 Both requesters valid continuously for 4 cycles, addrs 3 and 7 -> grants alternate 0,1,0,1; responses arrive at N+1 with matching ids.
REQ-032 req1 addr=9 granted while wr_en=1, wr_addr=9, wr_data=32'h12345678 -> rsp1_data=32'h12345678, not mux_out.
REQ-033 ZERO_R0=1, req0 addr=0, mux_out=32'hFFFFFFFF, and wr_en to addr 0 in the same cycle -> rsp0_data=32'h0.
REQ-034 rst asserted in a grant cycle -> no rspN_valid in the following cycle; after release, the first contention grants requester 0.
REQ-035 Idle for 3 cycles between two single-requester grants -> mux_enable=0 and mux_sel unchanged while idle; round-robin pointer unchanged.

Source files
------------

// File: rtl/regfile_read_arbiter_pkg.sv
// Shared widths, requester ids and the response pipeline record for the
// register-file read arbiter.
package regfile_read_arbiter_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned REG_DATA_W   = 32;
  localparam int unsigned NUM_READ_REQ = 2;

  typedef enum logic {
    REQ_ID_0 = 1'b0,
    REQ_ID_1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic                  valid;
    req_id_e               id;
    logic                  addr_is_zero;
    logic                  bypass_hit;
    logic [REG_DATA_W-1:0] bypass_data;
  } rsp_pipe_t;

endpackage

// File: rtl/regfile_read_arbiter_rr.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and
// moves only when a grant is issued.
module rr_arbiter2
  import regfile_read_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt          = '0;
    gnt_id       = 1'b0;
    last_grant_d = last_grant_q;
    if (!rst) begin
      // On contention favour the requester that did not win last time.
      if (req == 2'b11) begin
        gnt_id = ~last_grant_q;
      end else begin
        gnt_id = req[1];
      end
      if (|req) begin
        gnt          = gnt_id ? 2'b10 : 2'b01;
        last_grant_d = gnt_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Arbitrates two read requesters onto one shared registered 32:1 read mux,
// returning data one cycle after grant with write bypass and r0 zeroing.
module regfile_read_arbiter
  import regfile_read_arbiter_pkg::*;
#(
  parameter int ZERO_R0 = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [4:0]  mux_sel,
  output logic        mux_enable,
  input  logic [31:0] mux_out
);

  logic [1:0]            gnt;
  logic                  gnt_id;
  logic                  any_gnt;
  logic [REG_ADDR_W-1:0] gnt_addr;

  logic [REG_ADDR_W-1:0] mux_sel_q, mux_sel_d;
  rsp_pipe_t             pipe_q, pipe_d;
  logic [REG_DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [REG_DATA_W-1:0] rsp1_data_q, rsp1_data_d;
  logic [REG_DATA_W-1:0] rsp_data_now;
  logic                  rsp0_hit, rsp1_hit;

  rr_arbiter2 u_rr_arbiter2 (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    any_gnt   = |gnt;
    gnt_addr  = gnt_id ? req1_addr : req0_addr;
    mux_sel_d = mux_sel_q;
    if (any_gnt) begin
      mux_sel_d = gnt_addr;
    end

    pipe_d.valid        = any_gnt;
    pipe_d.id           = gnt_id ? REQ_ID_1 : REQ_ID_0;
    pipe_d.addr_is_zero = (ZERO_R0 != 0) && (gnt_addr == '0);
    pipe_d.bypass_hit   = wr_en && (wr_addr == gnt_addr);
    pipe_d.bypass_data  = wr_data;

    // Zeroing of r0 outranks the write bypass, which outranks the mux.
    if (pipe_q.addr_is_zero) begin
      rsp_data_now = '0;
    end else if (pipe_q.bypass_hit) begin
      rsp_data_now = pipe_q.bypass_data;
    end else begin
      rsp_data_now = mux_out;
    end

    rsp0_hit    = pipe_q.valid && (pipe_q.id == REQ_ID_0);
    rsp1_hit    = pipe_q.valid && (pipe_q.id == REQ_ID_1);
    rsp0_data_d = rsp0_hit ? rsp_data_now : rsp0_data_q;
    rsp1_data_d = rsp1_hit ? rsp_data_now : rsp1_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_sel_q   <= '0;
      pipe_q      <= '0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      mux_sel_q   <= mux_sel_d;
      pipe_q      <= pipe_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign mux_enable = any_gnt;
  assign mux_sel    = mux_sel_d;
  assign rsp0_valid = rsp0_hit;
  assign rsp1_valid = rsp1_hit;
  assign rsp0_data  = rsp0_data_d;
  assign rsp1_data  = rsp1_data_d;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0, mux_out = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, mux_enable;
  logic [31:0] rsp0_data, rsp1_data;
  logic [4:0]  mux_sel;

  int checks = 0;
  int failures = 0;

  // Behavioural model state, reflecting the DUT after a reset edge.
  int          prefer = 0;
  logic [4:0]  held_sel = '0;
  logic        p_valid = 1'b0;
  int          p_id = 0;
  logic        p_use_fixed = 1'b0;
  logic [31:0] p_fixed = '0;
  logic [31:0] hold [2] = '{32'h0, 32'h0};

  logic        s_r0, s_r1, s_en, s_rv0, s_rv1;
  logic [4:0]  s_sel;
  logic [31:0] s_d0, s_d1;

  regfile_read_arbiter #(.ZERO_R0(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mux_sel    (mux_sel),
    .mux_enable (mux_enable),
    .mux_out    (mux_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, then
  // advance the model across the next rising edge.
  task automatic step(input logic r, input logic v0, input logic [4:0] a0,
                      input logic v1, input logic [4:0] a1, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic [31:0] mo);
    int          g;
    logic [4:0]  ga, e_sel;
    logic [31:0] data, e_d0, e_d1;
    logic        e_v0, e_v1;
    @(posedge clk);
    #1;
    rst = r; req0_valid = v0; req0_addr = a0; req1_valid = v1; req1_addr = a1;
    wr_en = we; wr_addr = wa; wr_data = wd; mux_out = mo;
    #3;
    g = -1;
    if (!r) begin
      if (v0 && v1) g = prefer;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    ga    = (g == 1) ? a1 : a0;
    e_sel = (g >= 0) ? ga : held_sel;
    data  = p_use_fixed ? p_fixed : mo;
    e_v0  = p_valid && (p_id == 0);
    e_v1  = p_valid && (p_id == 1);
    e_d0  = e_v0 ? data : hold[0];
    e_d1  = e_v1 ? data : hold[1];

    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    chk("mux_enable", mux_enable, g >= 0);
    chk("mux_sel", mux_sel, e_sel);
    chk("rsp0_valid", rsp0_valid, e_v0);
    chk("rsp1_valid", rsp1_valid, e_v1);
    chk("rsp0_data", rsp0_data, e_d0);
    chk("rsp1_data", rsp1_data, e_d1);

    s_r0 = req0_ready; s_r1 = req1_ready; s_en = mux_enable; s_sel = mux_sel;
    s_rv0 = rsp0_valid; s_rv1 = rsp1_valid; s_d0 = rsp0_data; s_d1 = rsp1_data;

    if (r) begin
      prefer = 0; held_sel = '0; p_valid = 1'b0; p_use_fixed = 1'b0;
      hold[0] = '0; hold[1] = '0;
    end else begin
      if (e_v0) hold[0] = data;
      if (e_v1) hold[1] = data;
      p_valid = (g >= 0);
      if (g >= 0) begin
        prefer      = 1 - g;
        held_sel    = ga;
        p_id        = g;
        p_use_fixed = (ga == 5'd0) || (we && (wa == ga));
        p_fixed     = (ga == 5'd0) ? 32'h0 : wd;
      end
    end
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_rsp0_data", s_d0, 32'h0);
    chk("reset_mux_sel", s_sel, 5'd0);

    // Single request, data from the mux one cycle later.
    step(0, 1, 5, 0, 0, 0, 0, 0, 32'h0BAD0BAD);
    chk("lit_grant_r0", s_r0, 1'b1);
    chk("lit_grant_sel", s_sel, 5'd5);
    chk("lit_grant_en", s_en, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
    chk("lit_rsp0_valid", s_rv0, 1'b1);
    chk("lit_rsp0_data", s_d0, 32'hDEADBEEF);

    // Continuous contention after reset alternates starting with requester 0.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 3, 1, 7, 0, 0, 0, $urandom);
      chk("lit_alt_r0", s_r0, (i % 2) == 0);
      chk("lit_alt_r1", s_r1, (i % 2) == 1);
      if (i > 0) chk("lit_alt_rsp0", s_rv0, (i % 2) == 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("lit_alt_last_rsp1", s_rv1, 1'b1);

    // Write bypass beats the mux.
    step(0, 0, 0, 1, 9, 1, 9, 32'h12345678, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hAAAAAAAA);
    chk("lit_bypass_valid", s_rv1, 1'b1);
    chk("lit_bypass_data", s_d1, 32'h12345678);

    // r0 reads zero even with a same-cycle write to r0.
    step(0, 1, 0, 0, 0, 1, 0, 32'h55555555, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF);
    chk("lit_r0_valid", s_rv0, 1'b1);
    chk("lit_r0_data", s_d0, 32'h0);

    // Reset during a request: no grant, no response, requester 0 wins next.
    step(1, 1, 4, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_r0", s_r0, 1'b0);
    chk("lit_rst_en", s_en, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h1);
    chk("lit_post_rst_rsp0", s_rv0, 1'b0);
    chk("lit_post_rst_rsp1", s_rv1, 1'b0);
    step(0, 1, 2, 1, 6, 0, 0, 0, 0);
    chk("lit_post_rst_contend", s_r0, 1'b1);

    // Idle gap keeps mux_sel and the pointer.
    step(0, 0, 0, 1, 12, 0, 0, 0, 0);
    chk("lit_idle_pre_r1", s_r1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, $urandom);
      chk("lit_idle_en", s_en, 1'b0);
      chk("lit_idle_sel", s_sel, 5'd12);
    end
    step(0, 1, 1, 1, 2, 0, 0, 0, 0);
    chk("lit_idle_ptr", s_r0, 1'b1);

    // Randomized traffic with biased addresses to hit r0 and bypass often.
    for (int i = 0; i < 500; i++) begin
      logic        r, v0, v1, we;
      logic [4:0]  a0, a1, wa;
      r  = ($urandom_range(0, 39) == 0);
      v0 = $urandom_range(0, 1) != 0;
      v1 = $urandom_range(0, 1) != 0;
      a0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      we = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 2))
        0:       wa = a0;
        1:       wa = a1;
        default: wa = 5'($urandom);
      endcase
      step(r, v0, a0, v1, a1, we, wa, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
